regfile_scoreboard: RTL
=======================

# regfile_scoreboard

Parametrised multi-port integer register file with write-to-read bypass and a per-register busy scoreboard, replacing the single-write, two-read file in the core's decode stage. It serves NREAD combinational read ports and NWRITE synchronous write ports (ALU and load writeback). Destination registers are marked busy at issue and released at writeback, so decode can detect RAW hazards without its own tracking. Register 0 is hardwired to zero.

## Interface
- XLEN, 32: data width in bits
- NREGS, 32: number of architectural registers; power of two, at least 2
- NREAD, 2: number of read ports
- NWRITE, 2: number of write ports; a higher port index has higher priority
- AW, $clog2(NREGS): address width (derived, not overridable)

- clk  in  1  rising-edge clock; all state updates on the posedge
- reset  in  1  reset, synchronous, active-high
- rd_addr  in  NREAD*AW  packed read addresses; port i uses bits [i*AW +: AW]
- rd_data  out  NREAD*XLEN  packed read data, combinational
- rd_busy  out  NREAD  high when the read operand is still pending (hazard)
- wr_en  in  NWRITE  write strobe per port
- wr_addr  in  NWRITE*AW  packed write addresses
- wr_data  in  NWRITE*XLEN  packed write data
- wr_clr  in  NWRITE  when set with wr_en, the write also clears the busy bit of wr_addr
- iss_en  in  1  issue strobe; marks iss_addr busy
- iss_addr  in  AW  destination register of the issuing instruction
- busy_vec  out  NREGS  current scoreboard, registered
- wr_conflict  out  1  combinational; high when two or more enabled write ports target the same non-zero address

## Operation
- Storage:
  - NREGS x XLEN array plus an NREGS-bit busy vector.
  - Entry 0 and busy[0] are constant 0.
  - Writes and issues to address 0 are ignored.
- Write:
  - On each posedge with wr_en[j] set and wr_addr[j] != 0, the entry takes wr_data[j].
  - When several ports target the same address, the highest j wins.
  - Losing ports have no effect on the entry.
- Read port i, combinational:
  - rd_addr == 0 gives 0.
  - Otherwise, if any enabled write port targets rd_addr this cycle, the port returns the highest-index matching wr_data (bypass).
  - Otherwise it returns the stored entry.
- Busy update, next-state per register r != 0:
  - Set if iss_en && iss_addr == r.
  - Otherwise cleared if any j has wr_en[j] && wr_clr[j] && wr_addr[j] == r.
  - Otherwise held.
  - Issue wins over a simultaneous clear of the same register, because a new producer supersedes the old one.
- rd_busy[i]:
  - Equals busy[rd_addr[i]] && !(a clearing write to rd_addr[i] this cycle).
  - A same-cycle issue does not affect rd_busy; it becomes visible the next cycle.
  - rd_addr 0 always gives rd_busy 0.
- A write with wr_clr=0 updates data but leaves busy unchanged (used for speculative/early writes).
- wr_conflict is diagnostic only and has no effect on state.

## Timing
- Reset, synchronous, checked at the posedge and overriding all writes and issues in the same cycle:
  - All entries are set to 0.
  - busy_vec is set to 0.
- Output values after reset:
  - rd_data is 0 for every port, unless bypassing an active write.
  - rd_busy is 0.
  - busy_vec is 0.
  - wr_conflict follows its inputs (combinational).
- Read latency is 0 cycles (combinational from rd_addr, wr_*).
- A write at posedge N is visible from the array at cycle N+1, and visible through bypass during cycle N.
- Issue at posedge N: busy_vec and rd_busy reflect it from cycle N+1.
- Reset asserted mid-operation discards any write or issue in that cycle. No partial state survives.
- No combinational path from iss_en/iss_addr to any output.

## Test plan
- Reset, then read all 32 addresses on both ports -> every rd_data = 0, busy_vec = 0.
- Write x5 = 0xDEADBEEF on port 0, reading x5 the same cycle -> rd_data = 0xDEADBEEF (bypass); the next cycle still reads 0xDEADBEEF from the array.
- Same cycle, port 0 writes x7 = 0x11111111 and port 1 writes x7 = 0x22222222 -> wr_conflict = 1, same-cycle read = 0x22222222, stored x7 = 0x22222222.
- Write x0 = 0xFFFFFFFF and issue x0 -> rd_data for x0 = 0, busy_vec[0] = 0, wr_conflict = 0.
- Scoreboard sequence:
  - Issue x3 -> next cycle rd_busy = 1 for x3.
  - Write x3 with wr_clr=1 -> the same cycle gives rd_busy = 0 with bypass data; busy_vec[3] = 0 next cycle.
  - Issue x3 simultaneously with a clearing write to x3 -> busy_vec[3] = 1 next cycle.
- Fill x1..x31 with their own indices, then assert reset together with a write of x9 = 0xABCD -> all entries = 0 and busy_vec = 0 after the edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with same-cycle write bypass and a per-register
// busy scoreboard used by decode for RAW hazard detection. x0 reads as zero.
module regfile_scoreboard #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NWRITE = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREAD*$clog2(NREGS)-1:0]  rd_addr,
    output logic [NREAD*XLEN-1:0]    rd_data,
    output logic [NREAD-1:0]         rd_busy,
    input  logic [NWRITE-1:0]        wr_en,
    input  logic [NWRITE*$clog2(NREGS)-1:0] wr_addr,
    input  logic [NWRITE*XLEN-1:0]   wr_data,
    input  logic [NWRITE-1:0]        wr_clr,
    input  logic                     iss_en,
    input  logic [$clog2(NREGS)-1:0] iss_addr,
    output logic [NREGS-1:0]         busy_vec,
    output logic                     wr_conflict
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs   [NREGS];
    logic [NREGS-1:0] reg_we;
    logic [XLEN-1:0]  reg_wd [NREGS];
    logic [NREGS-1:0] clr_hit;
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    // Per-register write select; ascending loop lets the highest port index win.
    always_comb begin
        reg_we  = '0;
        clr_hit = '0;
        for (int r = 0; r < NREGS; r++) begin
            reg_wd[r] = '0;
        end
        for (int j = 0; j < NWRITE; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(0))) begin
                reg_we[wr_addr[j*AW +: AW]] = 1'b1;
                reg_wd[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
                if (wr_clr[j]) begin
                    clr_hit[wr_addr[j*AW +: AW]] = 1'b1;
                end
            end
        end
    end

    for (genvar r = 0; r < NREGS; r++) begin : g_entry
        always_ff @(posedge clk) begin
            if (reset) begin
                regs[r] <= '0;
            end else if (reg_we[r]) begin
                regs[r] <= reg_wd[r];
            end
        end
    end

    // Issue takes priority over a same-cycle clear: the new producer supersedes the old one.
    always_comb begin
        busy_nxt = busy & ~clr_hit;
        if (iss_en && (iss_addr != AW'(0))) begin
            busy_nxt[iss_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy_vec = busy;

    // Read ports: zero for x0, else bypass from the highest matching write port, else array.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (rd_addr[i*AW +: AW] != AW'(0)) begin
                rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
                for (int j = 0; j < NWRITE; j++) begin
                    if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
                        rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                    end
                end
                rd_busy[i] = busy[rd_addr[i*AW +: AW]] && !clr_hit[rd_addr[i*AW +: AW]];
            end
        end
    end

    always_comb begin
        wr_conflict = 1'b0;
        for (int j = 0; j < NWRITE; j++) begin
            for (int k = j + 1; k < NWRITE; k++) begin
                if (wr_en[j] && wr_en[k] && (wr_addr[j*AW +: AW] == wr_addr[k*AW +: AW])
                    && (wr_addr[j*AW +: AW] != AW'(0))) begin
                    wr_conflict = 1'b1;
                end
            end
        end
    end

endmodule
